// File: rtl/ev3a_fitness_eval.sv
// ev3a_fitness_eval
//   Sequential fitness evaluator for the EV3a lattice optimiser. An individual
//   (11 sites x 2 bits, plus an 8-bit mutation tag) is accepted in IDLE. It is
//   walked one site per cycle in CALC, and the result is registered in DONE.
//   A running minimum-fitness tracker keeps the best legal individual seen.
//
//   Ports
//     clk, rst            clock, asynchronous active-high reset
//     in_valid/in_ready   individual handshake (accepted when both high)
//     ind_state_in        lattice, site i = bits [2i+1:2i], 0 = empty
//     ind_mut_in          mutation-rate tag carried with the individual
//     self_energy         added per occupied site
//     interact_energy     added per adjacent, equal, occupied pair
//     Num_particleType    highest legal particle type
//     clr_best            synchronous clear of the best tracker
//     out_valid           one-cycle result pulse
//     fit_out/fit_state/fit_mut/illegal   last individual's result (held)
//     best_valid/Min_fit_out/Best_ind_state/Best_ind_mut   tracker outputs
//
//   Optional build macro EV3A_FIT_WRAP_EN: the lattice is periodic, so site 10
//   is also paired with site 0. Latency does not change.
module ev3a_fitness_eval #(
    parameter int INT8_LENGTH     = 8,
    parameter int ENERGY_LENGTH   = 4,
    parameter int PARTICLE_LENGTH = 2,
    parameter int LATTICE_LENGTH  = 11,
    parameter int IND_FIT_LENGTH  = 10
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [PARTICLE_LENGTH*LATTICE_LENGTH-1:0] ind_state_in,
    input  logic [INT8_LENGTH-1:0]                    ind_mut_in,
    input  logic [ENERGY_LENGTH-1:0]                  self_energy,
    input  logic [ENERGY_LENGTH-1:0]                  interact_energy,
    input  logic [PARTICLE_LENGTH-1:0]                Num_particleType,
    input  logic                                      clr_best,
    output logic                                      out_valid,
    output logic [IND_FIT_LENGTH-1:0]                 fit_out,
    output logic [PARTICLE_LENGTH*LATTICE_LENGTH-1:0] fit_state,
    output logic [INT8_LENGTH-1:0]                    fit_mut,
    output logic                                      illegal,
    output logic                                      best_valid,
    output logic [IND_FIT_LENGTH-1:0]                 Min_fit_out,
    output logic [PARTICLE_LENGTH*LATTICE_LENGTH-1:0] Best_ind_state,
    output logic [INT8_LENGTH-1:0]                    Best_ind_mut
);
    localparam int STATE_W = PARTICLE_LENGTH * LATTICE_LENGTH;
    localparam int IDX_W   = $clog2(LATTICE_LENGTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LATTICE_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [STATE_W-1:0]         lat_q;   // full lattice, kept for fit_state
    logic [STATE_W-1:0]         sh_q;    // shifts right one site per CALC cycle
    logic [INT8_LENGTH-1:0]     mut_q;
    logic [ENERGY_LENGTH-1:0]   self_q, inter_q;
    logic [PARTICLE_LENGTH-1:0] num_q;
    logic [PARTICLE_LENGTH-1:0] prev_q;  // previous site; 0 before site 0 so no pair
    logic [IND_FIT_LENGTH-1:0]  acc_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       ill_q;

    logic                       accept;
    logic [PARTICLE_LENGTH-1:0] cur;
    logic [IND_FIT_LENGTH-1:0]  add_self, add_int, add_wrap, acc_nxt;

    // The out_valid cycle is held off as well, giving 13 cycles per individual.
    assign in_ready = (state == IDLE) && !out_valid;
    assign accept   = in_valid && in_ready;
    assign cur      = sh_q[PARTICLE_LENGTH-1:0];

    always_comb begin
        add_self = '0;
        add_int  = '0;
        add_wrap = '0;
        if (cur != '0)
            add_self = IND_FIT_LENGTH'(self_q);
        if (cur != '0 && cur == prev_q)
            add_int = IND_FIT_LENGTH'(inter_q);
`ifdef EV3A_FIT_WRAP_EN
        if (idx_q == LAST_IDX && cur != '0 && cur == lat_q[PARTICLE_LENGTH-1:0])
            add_wrap = IND_FIT_LENGTH'(inter_q);
`endif
        acc_nxt = acc_q + add_self + add_int + add_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (idx_q == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_q          <= '0;
            sh_q           <= '0;
            mut_q          <= '0;
            self_q         <= '0;
            inter_q        <= '0;
            num_q          <= '0;
            prev_q         <= '0;
            acc_q          <= '0;
            idx_q          <= '0;
            ill_q          <= 1'b0;
            out_valid      <= 1'b0;
            fit_out        <= '0;
            fit_state      <= '0;
            fit_mut        <= '0;
            illegal        <= 1'b0;
            best_valid     <= 1'b0;
            Min_fit_out    <= '1;
            Best_ind_state <= '0;
            Best_ind_mut   <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    lat_q   <= ind_state_in;
                    sh_q    <= ind_state_in;
                    mut_q   <= ind_mut_in;
                    self_q  <= self_energy;
                    inter_q <= interact_energy;
                    num_q   <= Num_particleType;
                    prev_q  <= '0;
                    acc_q   <= '0;
                    idx_q   <= '0;
                    ill_q   <= 1'b0;
                end
                CALC: begin
                    acc_q  <= acc_nxt;
                    ill_q  <= ill_q | (cur > num_q);
                    prev_q <= cur;
                    sh_q   <= sh_q >> PARTICLE_LENGTH;
                    idx_q  <= idx_q + 1'b1;
                end
                DONE: begin
                    out_valid <= 1'b1;
                    fit_out   <= acc_q;
                    fit_state <= lat_q;
                    fit_mut   <= mut_q;
                    illegal   <= ill_q;
                    // strict '<' keeps the older entry on a tie
                    if (!ill_q && (!best_valid || acc_q < Min_fit_out)) begin
                        best_valid     <= 1'b1;
                        Min_fit_out    <= acc_q;
                        Best_ind_state <= lat_q;
                        Best_ind_mut   <= mut_q;
                    end
                end
                default: ;
            endcase
            // clear overrides a same-cycle tracker update
            if (clr_best) begin
                best_valid     <= 1'b0;
                Min_fit_out    <= '1;
                Best_ind_state <= '0;
                Best_ind_mut   <= '0;
            end
        end
    end
endmodule

// File: doc/ev3a_fitness_eval.md
Name: ev3a_fitness_eval

Overview:
- Sequential fitness evaluator for the EV3a evolutionary lattice optimiser.
- Takes one individual: an 11-site lattice state with 2 bits per site, plus an 8-bit mutation-rate tag.
- Walks the lattice one site per cycle and accumulates the individual's energy (fitness).
- Keeps a running minimum-fitness tracker whose best state, best mutation tag and minimum fitness feed the EV3a result outputs.

Parameters:
- INT8_LENGTH, 8, width of the mutation-rate tag.
- ENERGY_LENGTH, 4, width of the self and interaction energy coefficients.
- PARTICLE_LENGTH, 2, bits per lattice site (particle type).
- LATTICE_LENGTH, 11, number of lattice sites.
- IND_FIT_LENGTH, 10, width of the fitness value.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active high.
- in_valid  in  1  individual present on inputs.
- in_ready  out  1  block can accept an individual.
- ind_state_in  in  22  lattice; site i = bits [2i+1:2i]; value 0 = empty.
- ind_mut_in  in  8  mutation-rate tag carried with the individual.
- self_energy  in  4  energy added per occupied site.
- interact_energy  in  4  energy added per adjacent same-type occupied pair.
- Num_particleType  in  2  highest legal particle type.
- clr_best  in  1  synchronous clear of the best tracker.
- out_valid  out  1  one-cycle pulse: result valid.
- fit_out  out  10  fitness of the last individual.
- fit_state  out  22  state of the last individual.
- fit_mut  out  8  tag of the last individual.
- illegal  out  1  last individual contained a site type > Num_particleType.
- best_valid  out  1  tracker holds at least one legal result.
- Min_fit_out  out  10  minimum legal fitness since reset or clear.
- Best_ind_state  out  22  state achieving Min_fit_out.
- Best_ind_mut  out  8  tag achieving Min_fit_out.

Behaviour:
- Reset: async on rst high; state machine goes to IDLE.
  - in_ready=1.
  - out_valid, illegal, best_valid, fit_out, fit_state, fit_mut, Best_ind_state, Best_ind_mut = 0.
  - Min_fit_out=10'h3FF.
  - A reset during CALC discards the in-progress individual and emits no output.
- State machine: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge (accept edge t0): latch ind_state_in, ind_mut_in, self_energy, interact_energy and Num_particleType.
  - Clear the accumulator, site index and illegal flag; go to CALC.
- CALC: in_ready=0; in_valid is ignored. One site per cycle, index 0..10, at edges t0+1..t0+11.
  - Occupied site (value != 0): acc += self_energy.
  - For i>=1: if site i == site i-1 and both are nonzero, acc += interact_energy.
  - If site value > Num_particleType: set illegal. The site's energy is still accumulated.
  - After index 10, go to DONE.
- DONE:
  - At edge t0+12, register fit_out/fit_state/fit_mut/illegal and pulse out_valid=1 for exactly one cycle.
  - Go to IDLE; in_ready is high again after edge t0+13.
  - Throughput: 13 cycles per individual.
- Arithmetic: unsigned, 10-bit accumulator, no saturation needed.
  - Max without wrap: 11x15 + 10x15 = 315.
  - Max with wrap: 330.
- Tracker (evaluated in the DONE cycle): update Min_fit_out / Best_ind_state / Best_ind_mut and set best_valid when both hold:
  - illegal = 0, and
  - best_valid = 0 or fit < Min_fit_out.
  - On a tie the older entry is kept.
- clr_best: in any state, sets Min_fit_out=10'h3FF and best_valid=0; Best_ind_state and Best_ind_mut go to 0.
  - If it coincides with a DONE update, the clear wins and that result is not tracked.
  - out_valid/fit_out are still produced.
- fit_* and illegal hold their values until the next DONE.

Optional Feature:
- Macro: EV3A_FIT_WRAP_EN.
- Defined: periodic lattice. While processing site 10, also compare site 10 with site 0; add interact_energy if they are equal and nonzero. Latency is unchanged.
- Undefined: open chain with 10 adjacent pairs only.

Test Plan:
- State 22'h0, self=5, inter=3, Num=1 -> fit_out=0, illegal=0; out_valid high exactly 12 edges after accept, in_ready low through CALC and DONE.
- State 22'h155555 (all type 1), self=2, inter=1, Num=1 -> fit_out=32 (33 with EV3A_FIT_WRAP_EN).
- Sites alternating 1,2,...,1 (site0=1), self=3, inter=7, Num=2 -> fit_out=33 (40 with wrap).
- State 22'h3FFFFF, self=15, inter=15, Num=3 -> fit_out=315 (330 with wrap), no overflow.
- Type 3 at site 4, Num=2 -> illegal=1; tracker unchanged and best_valid stays 0 if empty; in_valid pulsed mid-CALC is ignored.
- Feed fitness 32 (mut 8'h10), then 20 (8'h20), then 20 (8'h30) -> Min_fit_out=20, Best_ind_mut=8'h20.
  - Then clr_best -> Min_fit_out=10'h3FF, best_valid=0.
  - Assert rst mid-CALC -> no out_valid, in_ready=1.
